// File: rtl/apb_uart_pkg.sv
// Shared types and UART register map for the APB initiator that fronts the UART peripheral.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_master_state_e;

    // UART peripheral register map, byte addresses on the APB bus
    localparam logic [31:0] UART_BAUD_CFG_ADDR   = 32'h0000_0000;
    localparam logic [31:0] UART_FRAME_CFG_ADDR  = 32'h0000_0004;
    localparam logic [31:0] UART_PARITY_CFG_ADDR = 32'h0000_0008;
    localparam logic [31:0] UART_STOP_CFG_ADDR   = 32'h0000_000C;
    localparam logic [31:0] UART_TX_DATA_ADDR    = 32'h0000_0010;
    localparam logic [31:0] UART_RX_DATA_ADDR    = 32'h0000_0014;

endpackage

// File: rtl/apb_wait_counter.sv
// Counts ACCESS cycles spent waiting for PREADY; flags the last cycle allowed before abort.
module apb_wait_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned CNT_WIDTH      = 20
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [CNT_WIDTH-1:0] TERM_COUNT = CNT_WIDTH'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_r;

    // Wait-cycle counter; clear wins over enable so leaving ACCESS always restarts it
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (enable) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == TERM_COUNT);

endmodule

// File: rtl/apb_uart_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer to the UART slave, one response out.
module apb_uart_master
    import apb_uart_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned CNT_WIDTH      = 20
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    apb_master_state_e state_r;
    logic              wait_clear_s;
    logic              wait_enable_s;
    logic              wait_terminal_s;

    assign cmd_ready = (state_r == IDLE) && !PRESET;

    // Counter runs only on stalled ACCESS cycles and restarts whenever the transfer leaves ACCESS
    always_comb begin
        wait_enable_s = (state_r == ACCESS) && !PREADY;
        wait_clear_s  = (state_r != ACCESS) || PREADY || wait_terminal_s;
    end

    apb_wait_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_WIDTH      (CNT_WIDTH)
    ) u_wait_counter (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .clear    (wait_clear_s),
        .enable   (wait_enable_s),
        .terminal (wait_terminal_s)
    );

    // Transfer FSM with registered APB and response outputs
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r     <= IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= ADDR_ZERO;
            PWDATA      <= DATA_ZERO;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= DATA_ZERO;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_write ? cmd_wdata : DATA_ZERO;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state_r <= SETUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state_r <= ACCESS;
                end
                ACCESS: begin
                    // A late PREADY on the last allowed cycle still completes normally
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? DATA_ZERO : PRDATA;
                        rsp_error   <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state_r     <= RESP;
                    end else if (wait_terminal_s) begin
                        rsp_rdata   <= DATA_ZERO;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        state_r     <= RESP;
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_uart_master.md
Name: apb_uart_master

Overview:
- APB initiator that drives the UART peripheral's APB slave port.
- Accepts single read/write commands on a valid/ready command channel and runs a standard two-phase APB transfer (SETUP, then ACCESS).
- Waits for PREADY, captures PRDATA/PSLVERR, and returns one response per command on a valid/ready response channel.
- A bounded wait counter aborts transfers the peripheral never completes, e.g. a TX whose done never arrives.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and cmd_addr
- DATA_WIDTH, 32, width of PWDATA, PRDATA, cmd_wdata and rsp_rdata
- TIMEOUT_CYCLES, 1048575, ACCESS cycles allowed without PREADY before abort; must be ≥ 1
- CNT_WIDTH, 20, width of the wait counter; must satisfy 2**CNT_WIDTH > TIMEOUT_CYCLES

Ports:
- PCLK  in  1  single clock; all logic on its rising edge
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_error  out  1  PSLVERR sampled, or timeout
- rsp_timeout  out  1  transfer aborted by the wait counter
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB transfer complete
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (PRESET high at a clock edge):
  - state goes to IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_error and rsp_timeout go to 0.
  - PADDR, PWDATA and rsp_rdata go to 0; the wait counter clears.
  - cmd_ready is (state==IDLE) && !PRESET, so it is 0 while PRESET is high.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge N, register cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA. PWDATA is 0 for reads.
  - Go to SETUP.
- SETUP (cycle N+1):
  - PSEL = 1, PENABLE = 0.
  - Unconditionally go to ACCESS.
- ACCESS (cycle N+2 onward):
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWRITE and PWDATA stay stable for the whole transfer.
  - Wait counter increments every ACCESS cycle in which PREADY = 0.
  - If PREADY = 1:
    - rsp_rdata ← PWRITE ? 0 : PRDATA.
    - rsp_error ← PSLVERR; rsp_timeout ← 0.
    - Go to RESP.
  - Else if counter == TIMEOUT_CYCLES-1:
    - rsp_rdata ← 0; rsp_error ← 1; rsp_timeout ← 1.
    - Go to RESP.
  - PREADY takes priority over the timeout in the same cycle.
  - Minimum latency: 3 cycles from command handshake to rsp_valid (zero-wait slave).
- RESP:
  - PSEL = 0, PENABLE = 0; rsp_valid = 1 and response fields held.
  - On rsp_ready go to IDLE and clear rsp_valid. The counter clears on leaving ACCESS.
- Throughput: the next command is accepted no earlier than the cycle after the response handshake. There is one outstanding transfer only; no back-to-back APB transfers.
- cmd_* are sampled only at the handshake edge; changes at any other time are ignored.
- Reset mid-transfer (any state): bus returns to idle the next edge, no response is produced, and a pending response is discarded.
- PRDATA and PSLVERR are ignored outside ACCESS.
- PADDR and PWDATA hold their last values in IDLE and RESP.

Decomposition:
- apb_uart_pkg holds:
  - typedef enum logic [1:0] apb_master_state_e {IDLE, SETUP, ACCESS, RESP}
  - localparams mirroring the UART register map (baud, frame, parity and stop-bits config addresses, TX and RX data addresses), for benches and host code
- One natural sub-module: apb_wait_counter (clear, enable, terminal-count flag at TIMEOUT_CYCLES-1).
- The FSM and datapath stay in apb_uart_master.

Test Plan:
- Config write, zero-wait slave:
  - Stimulus: cmd write, addr = baud config, wdata = 115200 at edge N.
  - Response: PSEL=1/PENABLE=0 at N+1, PENABLE=1 at N+2, rsp_valid at N+3; rsp_error=0, rsp_rdata=0.
- Readback with wait states:
  - Stimulus: read baud config; PREADY held low 5 ACCESS cycles, then PRDATA = 115200.
  - Response: rsp_rdata = 115200, rsp_valid at N+8, PADDR stable throughout.
- Slave error:
  - Stimulus: write to frame config with PSLVERR=1 and PREADY=1.
  - Response: rsp_error=1, rsp_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, PREADY never asserted.
  - Response: after 16 ACCESS cycles, PSEL drops and rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - Variant: PREADY=1 on the 16th cycle → normal completion.
- Back-pressure:
  - Stimulus: rsp_ready low 10 cycles with cmd_valid held high.
  - Response: rsp fields stable, cmd_ready=0; the second command is accepted the edge after the rsp handshake.
- Reset mid-ACCESS:
  - Stimulus: PRESET=1 for one edge during wait states.
  - Response: PSEL=PENABLE=0 and rsp_valid=0 next cycle, cmd_ready=1 the cycle after PRESET falls.
